// File: rtl/riscv_pkg.sv
// Shared core definitions: data width plus the memory-port arbiter's state,
// owner encodings and latency ceiling.
package riscv_pkg;

    localparam int XLEN                = 32;
    localparam int MEM_ARB_MAX_LATENCY = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        I    = 2'd1,
        D    = 2'd2
    } mem_arb_owner_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive fetch denials. o_sat tells the arbiter
// that fetch has waited long enough and must win the next grant slot.
// LIMIT must be at least 1.
module mem_arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    localparam int            W   = $clog2(LIMIT + 1);
    localparam logic [W-1:0]  LIM = W'(LIMIT);

    logic [W-1:0] r_cnt;

    // Clear on a fetch grant, otherwise count denials up to LIMIT and hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIM)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_sat = (r_cnt == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency, single-ported memory between instruction
// fetch (i_*) and data access (d_*). Data wins ties; one transaction is in
// flight at a time, and a new grant may overlap the previous response cycle.
// Build option: MEM_ARB_STARVE_GUARD_EN forces a fetch grant after
// STARVE_LIMIT consecutive fetch denials.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [XLEN-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [3:0]      d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            busy
);

    localparam int            CW       = $clog2(MEM_LATENCY) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

    if (MEM_LATENCY < 1 || MEM_LATENCY > MEM_ARB_MAX_LATENCY || STARVE_LIMIT < 1) begin : g_param_check
        $error("mem_port_arbiter: illegal MEM_LATENCY or STARVE_LIMIT");
    end

    mem_arb_state_t  r_state;
    mem_arb_owner_t  r_owner;
    logic [CW-1:0]   r_cnt;
    logic            r_store;

    logic w_can_grant;
    logic w_resp;
    logic w_starve_force;
    logic w_grant_d;
    logic w_grant_i;

    // A slot opens when idle or in the last cycle of the current transaction;
    // reset low closes it so grants are masked during reset.
    assign w_can_grant = reset && ((r_state == IDLE) || (r_cnt == '0));
    assign w_resp      = reset && (r_state == BUSY) && (r_cnt == '0);
    assign w_grant_d   = w_can_grant && d_req && !w_starve_force;
    assign w_grant_i   = w_can_grant && i_req && (!d_req || w_starve_force);

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic w_starve_inc;
    logic w_starve_sat;

    // A denial counts only when fetch was asking and data took the slot.
    assign w_starve_inc = i_req && w_grant_d;

    mem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_starve_inc),
        .i_clr (w_grant_i),
        .o_sat (w_starve_sat)
    );

    assign w_starve_force = w_starve_sat && i_req;
`else
    assign w_starve_force = 1'b0;
`endif

    // Transaction FSM: a grant (re)arms the latency counter; with no new
    // grant the response cycle returns to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_owner <= NONE;
            r_cnt   <= '0;
            r_store <= 1'b0;
        end else if (w_grant_d || w_grant_i) begin
            r_state <= BUSY;
            r_owner <= w_grant_d ? D : I;
            r_cnt   <= CNT_INIT;
            r_store <= w_grant_d && d_we;
        end else if (r_state == BUSY) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end else begin
                r_state <= IDLE;
                r_owner <= NONE;
                r_store <= 1'b0;
            end
        end
    end

    // Grant, memory command and response routing; everything idles at 0.
    always_comb begin
        i_gnt     = w_grant_i;
        d_gnt     = w_grant_d;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 4'b0000;
        i_rvalid  = 1'b0;
        i_rdata   = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;

        if (w_grant_d) begin
            mem_req   = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
        end else if (w_grant_i) begin
            mem_req   = 1'b1;
            mem_addr  = i_addr;
            mem_be    = 4'b1111;
        end

        if (w_resp) begin
            if (r_owner == I) begin
                i_rvalid = 1'b1;
                i_rdata  = mem_rdata;
            end else if (r_owner == D) begin
                d_rvalid = 1'b1;
                d_rdata  = r_store ? '0 : mem_rdata;
            end
        end
    end

    assign busy = reset && (r_state == BUSY);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one single-ported, fixed-latency memory between instruction fetch (IF stage) and data access (MEM stage).
- Sits between the two stages and the memory array.
- Grants one transaction at a time, gives data priority over fetch, and routes the returning read data to the owner.
- Grant denials feed the hazard unit as fetch and memory stalls.

## Interface
Parameters:
- MEM_LATENCY, 2: cycles from the memory command cycle to `mem_rdata` valid; legal values are 1 to 8.
- STARVE_LIMIT, 4: number of consecutive fetch denials that forces a fetch grant (only with `MEM_ARB_STARVE_GUARD_EN`).

Ports (XLEN comes from riscv_pkg):
- clk  in  1  the only clock.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; must hold until `i_gnt`.
- i_addr  in  XLEN  fetch word address.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  fetch data valid pulse.
- i_rdata  out  XLEN  fetch data.
- d_req  in  1  data request; must hold until `d_gnt`.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  XLEN  data address.
- d_wdata  in  XLEN  store data.
- d_be  in  4  byte enables.
- d_gnt  out  1  data accepted this cycle.
- d_rvalid  out  1  load data or store acknowledge pulse.
- d_rdata  out  XLEN  load data.
- mem_req  out  1  memory command strobe.
- mem_we  out  1  memory write.
- mem_addr  out  XLEN  memory address.
- mem_wdata  out  XLEN  memory write data.
- mem_be  out  4  memory byte enables.
- mem_rdata  in  XLEN  memory read data, valid MEM_LATENCY cycles after `mem_req`.
- busy  out  1  a transaction is outstanding.

## Operation
- The FSM has two states, IDLE and BUSY; the owner register holds NONE, I or D.
- The arbiter may grant when the state is IDLE, or when the state is BUSY and `cnt == 0`.
- Grant rule: if `d_req` is set, grant D; otherwise, if `i_req` is set, grant I. The starvation override is described under Configuration.
- On a grant:
  - `x_gnt` = 1 combinationally.
  - `mem_*` is driven from the winner's inputs; `mem_req` = 1.
  - On the next edge: state → BUSY, owner ← winner, `cnt` ← MEM_LATENCY-1.
- In BUSY:
  - While `cnt > 0`: `cnt` decrements each cycle and `mem_req` = 0.
  - When `cnt == 0`: the response cycle.
- Response cycle:
  - The owner's `x_rvalid` = 1.
  - The owner's `x_rdata` = `mem_rdata`; for a store, `d_rdata` = 0.
  - The non-owner's `rdata` = 0.
- If no grant happens in the response cycle, the next edge sets state → IDLE and owner ← NONE.
- Stores occupy the port for the full MEM_LATENCY; `d_rvalid` is the store acknowledge.
- `busy` = (state == BUSY).
- All `gnt`, `rvalid`, `rdata` and `mem_*` outputs are 0 whenever no grant or response applies.

## Timing
- Reset values: state IDLE, owner NONE, `cnt` 0, starvation counter 0.
- While reset is low, every output is held at 0; the `gnt` and `mem_*` outputs are masked.
- Latency: a grant at cycle T gives `rvalid` at T+MEM_LATENCY.
- Throughput: one transaction per MEM_LATENCY cycles, because a new grant may coincide with the previous response. With MEM_LATENCY = 1, back-to-back every cycle.
- Simultaneous `i_req` and `d_req`: D wins; I sees `i_gnt` = 0 and keeps requesting.
- A request deasserted before its grant is legal and has no effect.
- Reset asserted mid-transaction: the transaction is dropped, no `rvalid` is ever produced for it, and the late `mem_rdata` is ignored.
- `cnt` is `$clog2(MEM_LATENCY)+1` bits wide and never wraps.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A saturating counter increments in every cycle where `i_req` = 1, a grant is possible, and D is granted.
  - It clears when I is granted.
  - When it equals STARVE_LIMIT and `i_req` = 1, I wins even if `d_req` = 1.
- Without the macro: strict data priority and no counter logic.

## Structure
- riscv_pkg gains:
  - `mem_arb_state_t` enum (IDLE, BUSY).
  - `mem_arb_owner_t` enum (NONE, I, D).
  - `MEM_ARB_MAX_LATENCY` = 8.
- One sub-module, `mem_arb_starve_ctr`, holds the saturating counter. It is instantiated only under `MEM_ARB_STARVE_GUARD_EN`.

## Test plan
- Single fetch, MEM_LATENCY = 2: `i_req` at cycle 0 with `i_addr` = 0x100 → `i_gnt` at cycle 0, `mem_addr` = 0x100, `i_rvalid` at cycle 2 with `i_rdata` = memory word.
- Collision: `i_req` and `d_req` both at cycle 0 (load 0x200) → `d_gnt` at cycle 0, `d_rvalid` at cycle 2, `i_gnt` at cycle 2, `i_rvalid` at cycle 4.
- Store: `d_we` = 1, `d_be` = 4'b0011, `d_wdata` = 0xDEADBEEF → `mem_we` = 1 with the same `be` and `wdata`; `d_rvalid` at T+2 with `d_rdata` = 0; a read-back returns 0x0000BEEF over 0.
- MEM_LATENCY = 1 with continuous `i_req` → `i_gnt` and `i_rvalid` are 1 every cycle after the first, `busy` stays 1.
- `d_req` held high and `i_req` held high, with the macro and STARVE_LIMIT = 4 → four D grants, then one I grant. Without the macro → I is never granted.
- Reset pulled low at T+1 of a load → all outputs 0 immediately, no `d_rvalid` after release, `busy` = 0.
